// File: rtl/vga_pkg.sv
// Shared 800x600@60 timing defaults, cursor/colour defaults and RGB masks.
// Masks are {red, green, blue}; each bit expands to a full-scale channel.
package vga_pkg;

  localparam int H_SYNC_DEF   = 128;
  localparam int H_BACK_DEF   = 88;
  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FRONT_DEF  = 40;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BACK_DEF   = 23;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FRONT_DEF  = 1;

  localparam int CUR_SIZE_DEF = 8;
  localparam int COLOR_W_DEF  = 4;
  localparam int ACC_W_DEF    = 12;

  typedef logic [2:0] rgb_mask_t;

  localparam rgb_mask_t RGB_BLACK  = 3'b000;
  localparam rgb_mask_t RGB_RED    = 3'b100;
  localparam rgb_mask_t RGB_GREEN  = 3'b010;
  localparam rgb_mask_t RGB_BLUE   = 3'b001;
  localparam rgb_mask_t RGB_YELLOW = 3'b110;
  localparam rgb_mask_t RGB_WHITE  = 3'b111;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with active-region and frame-start flags.
// Flags are combinational from the counter registers; the caller registers them.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int HCW      = $clog2(H_SYNC + H_BACK + H_ACTIVE + H_FRONT),
  parameter int VCW      = $clog2(V_SYNC + V_BACK + V_ACTIVE + V_FRONT)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  output logic [HCW-1:0] h_cnt_o,
  output logic [VCW-1:0] v_cnt_o,
  output logic           active_o,
  output logic           frame_start_o
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + HCW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HCW'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VCW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VCW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign active_o      = (h_cnt_q >= HCW'(H_START)) && (h_cnt_q < HCW'(H_START + H_ACTIVE)) &&
                         (v_cnt_q >= VCW'(V_START)) && (v_cnt_q < VCW'(V_START + V_ACTIVE));
  assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_cursor_gen.sv
// VGA raster with a mouse-driven square cursor; motion accumulates during a frame
// and commits at frame start. Sync, colour and frame-start are registered (1 cycle).
module vga_cursor_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int CUR_SIZE = CUR_SIZE_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iMoveValid,
  input  logic [8:0]                    iDx,
  input  logic [8:0]                    iDy,
  input  logic [2:0]                    iButton,
  output logic                          oHs,
  output logic                          oVs,
  output logic [COLOR_W-1:0]            oRed,
  output logic [COLOR_W-1:0]            oGreen,
  output logic [COLOR_W-1:0]            oBlue,
  output logic [$clog2(H_ACTIVE)-1:0]   oCursorX,
  output logic [$clog2(V_ACTIVE)-1:0]   oCursorY,
  output logic                          oFrameStart
);

  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int HCW     = $clog2(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
  localparam int VCW     = $clog2(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  // Wide enough that position + accumulator can never overflow before clamping.
  localparam int CW      = max_int(ACC_W, max_int(XW, YW) + 1) + 1;
  localparam logic signed [CW-1:0] X_MAX = CW'(H_ACTIVE - CUR_SIZE);
  localparam logic signed [CW-1:0] Y_MAX = CW'(V_ACTIVE - CUR_SIZE);

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           active, frame_start;

  vga_timing #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT),
    .HCW(HCW), .VCW(VCW)
  ) u_timing (
    .clk_i        (iClk),
    .rst_i        (iRst),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .active_o     (active),
    .frame_start_o(frame_start)
  );

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W:0]   b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + b;
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  function automatic logic signed [CW-1:0] clamp_cw(input logic signed [CW-1:0] v,
                                                    input logic signed [CW-1:0] hi);
    if (v[CW-1]) return '0;
    if (v > hi) return hi;
    return v;
  endfunction

  logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_x_base, acc_y_base;
  logic signed [ACC_W:0]   dx_ext, dy_neg;
  logic signed [CW-1:0]    sum_x, sum_y;
  logic [XW-1:0]           pos_x_q, pos_x_d;
  logic [YW-1:0]           pos_y_q, pos_y_d;

  assign dx_ext = {{(ACC_W-8){iDx[8]}}, iDx};
  assign dy_neg = -{{(ACC_W-8){iDy[8]}}, iDy};
  assign sum_x  = $signed({{(CW-XW){1'b0}}, pos_x_q}) + $signed({{(CW-ACC_W){acc_x_q[ACC_W-1]}}, acc_x_q});
  assign sum_y  = $signed({{(CW-YW){1'b0}}, pos_y_q}) + $signed({{(CW-ACC_W){acc_y_q[ACC_W-1]}}, acc_y_q});

  // Commit uses the pre-frame accumulator; a packet on the commit cycle seeds the next one.
  always_comb begin
    acc_x_base = frame_start ? '0 : acc_x_q;
    acc_y_base = frame_start ? '0 : acc_y_q;
    acc_x_d    = iMoveValid ? sat_add(acc_x_base, dx_ext) : acc_x_base;
    acc_y_d    = iMoveValid ? sat_add(acc_y_base, dy_neg) : acc_y_base;
    pos_x_d    = frame_start ? XW'(clamp_cw(sum_x, X_MAX)) : pos_x_q;
    pos_y_d    = frame_start ? YW'(clamp_cw(sum_y, Y_MAX)) : pos_y_q;
  end

  logic [HCW:0] h_rel;
  logic [VCW:0] v_rel;
  logic         hit;
  rgb_mask_t    mask;

  assign h_rel = {1'b0, h_cnt} - (HCW+1)'(H_START);
  assign v_rel = {1'b0, v_cnt} - (VCW+1)'(V_START);
  assign hit   = (h_rel >= (HCW+1)'(pos_x_q)) && (h_rel < (HCW+1)'(pos_x_q) + (HCW+1)'(CUR_SIZE)) &&
                 (v_rel >= (VCW+1)'(pos_y_q)) && (v_rel < (VCW+1)'(pos_y_q) + (VCW+1)'(CUR_SIZE));

  always_comb begin
    mask = RGB_BLACK;
    if (active) begin
      if (hit) begin
        if (iButton[2])      mask = RGB_GREEN;
        else if (iButton[1]) mask = RGB_BLUE;
        else if (iButton[0]) mask = RGB_YELLOW;
        else                 mask = RGB_WHITE;
      end else begin
        mask = RGB_RED;
      end
    end
  end

  logic               hs_q, hs_d, vs_q, vs_d, fs_q;
  logic [COLOR_W-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;

  always_comb begin
    hs_d  = (h_cnt >= HCW'(H_SYNC));
    vs_d  = (v_cnt >= VCW'(V_SYNC));
    red_d = {COLOR_W{mask[2]}};
    grn_d = {COLOR_W{mask[1]}};
    blu_d = {COLOR_W{mask[0]}};
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fs_q    <= 1'b0;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= frame_start;
      red_q   <= red_d;
      grn_q   <= grn_d;
      blu_q   <= blu_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end

  assign oHs         = hs_q;
  assign oVs         = vs_q;
  assign oFrameStart = fs_q;
  assign oRed        = red_q;
  assign oGreen      = grn_q;
  assign oBlue       = blu_q;
  assign oCursorX    = pos_x_q;
  assign oCursorY    = pos_y_q;

endmodule

// File: doc/vga_cursor_gen.md
VGA_CURSOR_GEN -- requirements
Module: vga_cursor_gen

Interface
REQ-001 SHALL have parameter H_SYNC, default 128, hsync pulse width in pixel clocks.
REQ-002 SHALL have parameter H_BACK, default 88, horizontal back porch.
REQ-003 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-004 SHALL have parameter H_FRONT, default 40, horizontal front porch; H_TOTAL = sum of all four horizontal parameters.
REQ-005 SHALL have parameters V_SYNC, V_BACK, V_ACTIVE, V_FRONT, defaults 4 / 23 / 600 / 1, vertical equivalents in lines; V_TOTAL = their sum.
REQ-006 SHALL have parameter CUR_SIZE, default 8, cursor square edge in pixels.
REQ-007 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-008 SHALL have parameter ACC_W, default 12, signed pending-motion accumulator width.
REQ-009 Ports, clock and reset first:
- iClk  in  1  pixel clock
- iRst  in  1  reset; synchronous, active-high
- iMoveValid  in  1  one-cycle pulse; a motion packet is present
- iDx  in  9  signed two's-complement X delta
- iDy  in  9  signed two's-complement Y delta; positive means up
- iButton  in  3  {middle, right, left}, level
- oHs  out  1  hsync, active-low
- oVs  out  1  vsync, active-low
- oRed, oGreen, oBlue  out  COLOR_W each  pixel colour
- oCursorX  out  clog2(H_ACTIVE)  committed cursor X
- oCursorY  out  clog2(V_ACTIVE)  committed cursor Y
- oFrameStart  out  1  one-cycle pulse when hCnt=0 and vCnt=0

Function
REQ-010 hCnt SHALL count 0..H_TOTAL-1 and wrap. vCnt SHALL advance once, on the cycle hCnt wraps, over 0..V_TOTAL-1 and wrap.
REQ-011 The sync pulse SHALL be low while hCnt < H_SYNC (oHs) and while vCnt < V_SYNC (oVs).
REQ-012 Active region: H_SYNC+H_BACK <= hCnt < H_SYNC+H_BACK+H_ACTIVE, with the vertical equivalent. This is strictly H_ACTIVE x V_ACTIVE pixels.
REQ-013 oHs, oVs, RGB and oFrameStart SHALL all be registered, with exactly 1-cycle latency from the counter state and mutually aligned.
REQ-014 Each iMoveValid SHALL add the sign-extended iDx to the X accumulator and subtract the sign-extended iDy from the Y accumulator. Each accumulator SHALL saturate at the ACC_W signed limits.
REQ-015 On the frame-start cycle, the committed position SHALL be set to clamp(pos + acc). X clamps to 0..H_ACTIVE-CUR_SIZE; Y clamps to 0..V_ACTIVE-CUR_SIZE. The position never changes mid-frame.
REQ-016 On the frame-start cycle the accumulators SHALL reload with 0. If iMoveValid is asserted in the same cycle, they reload with that packet's delta instead, so no packet is lost.
REQ-017 Clamp arithmetic SHALL be performed at a signed width of at least max(ACC_W, position width+1)+1 bits, so that no overflow can occur.
REQ-018 Cursor hit: pixel x in [curX, curX+CUR_SIZE-1] and pixel y in [curY, curY+CUR_SIZE-1], where x and y are active-relative.
REQ-019 Colour priority within the active region:
- cursor hit with iButton[2]: green only at full scale
- else cursor hit with iButton[1]: blue only at full scale
- else cursor hit with iButton[0]: red+green at full scale
- else cursor hit: white (all channels full scale)
- no hit: red only at full scale
REQ-020 Outside the active region, all colour outputs SHALL be 0.
REQ-021 oCursorX/oCursorY SHALL reflect the committed position only.

Reset
REQ-022 While iRst is high at a clock edge, the block SHALL clear hCnt, vCnt, accumulators and position to 0.
REQ-023 On the cycle after reset, outputs SHALL be: oHs=0, oVs=0, RGB=0, oFrameStart=0, oCursorX=0, oCursorY=0.
REQ-024 A reset asserted mid-frame SHALL discard pending motion. The first oFrameStart SHALL occur 1 cycle after reset deasserts.

Structure
REQ-025 The default 800x600@60 timing constants and the colour constants SHALL reside in the shared package vga_pkg.
REQ-026 Sync generation SHALL be a sub-module, vga_timing, which outputs hCnt, vCnt, active and frame-start. The cursor accumulation, clamping and colour logic SHALL stay in the top level.

Verification
REQ-027 Defaults, one full frame -> oHs low for 128 of every 1056 cycles; oVs low for 4 of 628 lines; oFrameStart period is 663168 cycles.
REQ-028 iDx=+100 in frame N -> oCursorX changes from 0 to 100 exactly 1 cycle after the next frame start; it stays at 0 throughout frame N.
REQ-029 Ten packets of iDx=+255 in one frame -> oCursorX=792 (clamped). Then iDy=+50 from the origin -> oCursorY=0 (clamped; up is negative Y).
REQ-030 Packet iDx=-20 on the exact frame-start cycle, position 50 -> commit uses the prior accumulator. The -20 applies at the following frame: 50 then 30.
REQ-031 Position (0,0), iButton=3'b110 -> pixels at active (0..7, 0..7) are green (0,F,0); the pixel at (8,0) is red; blanking is 0.
REQ-032 Assert iRst mid-line with +40 pending -> all outputs 0 on the next cycle; the first frame after reset shows oCursorX=0.
